// File: rtl/prog_loader.sv
// Host program loader / readback port for the 32x8 memory of the accumulator core.
// Latency: write strobe 1 cycle after each data byte; read byte valid 1 cycle after fetch (peak 1 byte / 2 cycles).
// Backpressure: host_ready low during readback; rd_data held stable until rd_ready accepts it.
//
// Ports:
//   clk, rst                          clock and synchronous active-high reset
//   host_data/host_valid/host_ready   command, length and data byte stream from host
//   rd_data/rd_valid/rd_ready         readback byte stream to host
//   mem_we/mem_addr/mem_wdata         memory write port (mem_addr also addresses reads)
//   mem_rdata                         combinational memory read data
//   cpu_halt, busy, err               core halt, loader busy, sticky reserved-bit error
module prog_loader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_halt,
  output logic              busy,
  output logic              err
);

  // count holds 1..2^ADDR_W, so it needs one bit more than an address
  localparam int CW = ADDR_W + 1;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_READ  = 2'b10;
  localparam logic [1:0] CMD_RUN   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_WDATA,
    S_RFETCH,
    S_RSEND
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [CW-1:0]       r_count;
  logic                r_is_read;
  logic                r_halt;
  logic                r_err;
  logic                r_we;
  logic [ADDR_W-1:0]   r_waddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_rd_valid;

  logic                w_host_acc;
  logic                w_rd_acc;
  logic [1:0]          w_cmd;
  logic                w_rsvd;
  logic                w_last;

  assign w_host_acc = host_valid & host_ready;
  assign w_rd_acc   = r_rd_valid & rd_ready;
  assign w_cmd      = host_data[7:6];
  assign w_rsvd     = host_data[5];
  assign w_last     = (r_count == CW'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_host_acc && !w_rsvd && (w_cmd == CMD_WRITE || w_cmd == CMD_READ))
          w_next = S_LEN;
      end
      S_LEN: begin
        if (w_host_acc) w_next = r_is_read ? S_RFETCH : S_WDATA;
      end
      S_WDATA: begin
        if (w_host_acc && w_last) w_next = S_IDLE;
      end
      S_RFETCH: w_next = S_RSEND;
      S_RSEND: begin
        if (w_rd_acc) w_next = w_last ? S_IDLE : S_RFETCH;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    host_ready = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE:  begin host_ready = 1'b1; busy = 1'b0; end
      S_LEN:   host_ready = 1'b1;
      S_WDATA: host_ready = 1'b1;
      default: host_ready = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_is_read  <= 1'b0;
      r_halt     <= 1'b1;
      r_err      <= 1'b0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_host_acc) begin
            if (w_rsvd) begin
              r_err <= 1'b1;
            end else begin
              case (w_cmd)
                CMD_RUN: r_halt <= 1'b0;
                CMD_WRITE, CMD_READ: begin
                  r_addr    <= host_data[ADDR_W-1:0];
                  r_halt    <= 1'b1;
                  r_is_read <= (w_cmd == CMD_READ);
                end
                default: ;  // NOP
              endcase
            end
          end
        end
        S_LEN: begin
          if (w_host_acc) r_count <= {1'b0, host_data[ADDR_W-1:0]} + CW'(1);
        end
        S_WDATA: begin
          if (w_host_acc) begin
            r_we    <= 1'b1;
            r_waddr <= r_addr;
            r_wdata <= host_data;
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= r_count - CW'(1);
          end
        end
        S_RFETCH: begin
          r_rd_data  <= mem_rdata;
          r_rd_valid <= 1'b1;
        end
        S_RSEND: begin
          if (w_rd_acc) begin
            r_rd_valid <= 1'b0;
            r_addr     <= r_addr + ADDR_W'(1);
            r_count    <= r_count - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // The write address is registered with the data; otherwise the
  // address register drives the shared port for reads.
  assign mem_addr  = r_we ? r_waddr : r_addr;
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign cpu_halt  = r_halt;
  assign err       = r_err;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_data;
  logic       host_valid;
  logic       host_ready;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic       mem_we;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       cpu_halt;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  prog_loader #(.ADDR_W(5), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .host_data  (host_data),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .cpu_halt   (cpu_halt),
    .busy       (busy),
    .err        (err)
  );

  // Memory behind the loader
  logic [7:0] mem [32];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  // Scoreboard
  typedef struct packed {
    logic [4:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t        wq[$];
  logic [7:0] rq[$];
  logic [7:0] ref_mem [32];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         rd_xfers = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled away from the active edge
  always @(negedge clk) begin
    wr_t        e;
    logic [7:0] r;
    if (mem_we) begin
      if (wq.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
      else begin
        e = wq.pop_front();
        chk("we_addr", 32'(mem_addr), 32'(e.a));
        chk("we_data", 32'(mem_wdata), 32'(e.d));
      end
    end
    if (rd_valid && rd_ready) begin
      rd_xfers++;
      if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        r = rq.pop_front();
        chk("rd_data", 32'(rd_data), 32'(r));
      end
    end
  end

  // Called and returns at posedge+1
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    host_data  = b;
    host_valid = 1'b1;
    @(negedge clk);
    while (!host_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!host_ready) chk("host_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    host_valid = 1'b0;
    host_data  = 8'h00;
  endtask

  task automatic do_write(input logic [4:0] a, input int n, input logic [31:0] d);
    logic [4:0] ai;
    logic [7:0] b;
    send_byte({3'b010, a});
    send_byte(8'(n - 1));
    for (int i = 0; i < n; i++) begin
      ai = a + 5'(i);
      b  = d[8*i +: 8];
      ref_mem[ai] = b;
      wq.push_back({ai, b});
      send_byte(b);
    end
  endtask

  task automatic do_read(input logic [4:0] a, input int n);
    logic [4:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 5'(i);
      rq.push_back(ref_mem[ai]);
    end
    send_byte({3'b100, a});
    send_byte(8'(n - 1));
  endtask

  // Waits for the loader to go idle with all expected output seen
  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while ((busy || wq.size() != 0 || rq.size() != 0) && n < 300) begin
      if (busy) chk("host_ready_in_read", 32'(host_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("wait_done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int n;
    rst        = 1'b1;
    host_valid = 1'b1;
    host_data  = 8'hFF;
    rd_ready   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_host_ready", 32'(host_ready), 32'd1);
    chk("rst_rd_valid",   32'(rd_valid),   32'd0);
    chk("rst_rd_data",    32'(rd_data),    32'd0);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   32'(mem_addr),   32'd0);
    chk("rst_mem_wdata",  32'(mem_wdata),  32'd0);
    chk("rst_cpu_halt",   32'(cpu_halt),   32'd1);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_err",        32'(err),        32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    host_valid = 1'b0;
    host_data  = 8'h00;

    // WRITE @3, three bytes
    send_byte(8'h43);
    @(negedge clk);
    chk("wr_busy_after_cmd", 32'(busy), 32'd1);
    chk("wr_halt_after_cmd", 32'(cpu_halt), 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h02);
    wq.push_back({5'd3, 8'hAA}); ref_mem[3] = 8'hAA; send_byte(8'hAA);
    chk("wr_busy_mid", 32'(busy), 32'd1);
    wq.push_back({5'd4, 8'hBB}); ref_mem[4] = 8'hBB; send_byte(8'hBB);
    wq.push_back({5'd5, 8'hCC}); ref_mem[5] = 8'hCC; send_byte(8'hCC);
    @(negedge clk);
    chk("wr_busy_after_last", 32'(busy), 32'd0);
    chk("wr_we_after_last", 32'(mem_we), 32'd1);
    chk("wr_halt_end", 32'(cpu_halt), 32'd1);
    @(posedge clk);
    #1;
    wait_done();

    // Preload 30,31,0,1 (write wrap) then read back with wrap
    do_write(5'd30, 4, 32'h44332211);
    wait_done();
    do_read(5'd30, 4);
    wait_done();

    // Same read with a 5-cycle stall on the second byte
    base = rd_xfers;
    do_read(5'd30, 4);
    n = 0;
    while (rd_xfers < base + 1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (rd_xfers < base + 1) chk("stall_first_timeout", 32'd0, 32'd1);
    rd_ready = 1'b0;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_rd_valid", 32'(rd_valid), 32'd1);
      chk("stall_rd_data",  32'(rd_data),  32'h22);
      chk("stall_mem_addr", 32'(mem_addr), 32'd31);
    end
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    wait_done();

    // RUN then WRITE @31 re-halts
    send_byte(8'hC0);
    @(negedge clk);
    chk("run_halt", 32'(cpu_halt), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h5F);
    @(negedge clk);
    chk("rehalt", 32'(cpu_halt), 32'd1);
    @(posedge clk);
    #1;
    send_byte(8'h00);
    wq.push_back({5'd31, 8'h7E}); ref_mem[31] = 8'h7E; send_byte(8'h7E);
    wait_done();
    chk("mem31", 32'(mem[31]), 32'h7E);

    // Reserved bit sets sticky error
    send_byte(8'h20);
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("err_idle", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    send_byte(8'h41);
    send_byte(8'h00);
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    chk("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_err", 32'(err), 32'd0);
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_halt", 32'(cpu_halt), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("mem1_untouched", 32'(mem[1]), 32'h44);

    chk("wq_left", 32'(wq.size()), 32'd0);
    chk("rq_left", 32'(rq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
